// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: two-requester round-robin front end for an i2c_master.
// A granted request is latched, then start is held for HOLD_CYCLES cycles,
// stop for STOP_CYCLES cycles, and a one-cycle done pulse closes it out.
module i2c_cmd_arbiter #(
  parameter int HOLD_CYCLES = 20,
  parameter int STOP_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       start,
  output logic       stop,
  output logic       rw,
  output logic [6:0] addr,
  output logic [7:0] w_data
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);
  localparam logic [7:0] STOP_LOAD = 8'(STOP_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    STOP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] count;
  logic [7:0] count_next;
  logic       pointer;
  logic       winner;
  logic       winner_q;
  logic       grant_now;

  // Next-state, counter reload and strobe decode; the counter is reloaded on
  // every state entry and a phase ends on the cycle it reads 1.
  always_comb begin
    next_state = state;
    count_next = count;
    grant_now  = 1'b0;
    start      = 1'b0;
    stop       = 1'b0;
    busy       = 1'b1;
    done       = 2'b00;
    // A lone request wins outright; a tie goes to the pointer's requester.
    if (req0 && req1) begin
      winner = pointer;
    end else begin
      winner = req1;
    end
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req0 || req1) begin
          grant_now  = 1'b1;
          next_state = START;
          count_next = HOLD_LOAD;
        end
      end
      START: begin
        start = 1'b1;
        if (count == 8'd1) begin
          next_state = STOP;
          count_next = STOP_LOAD;
        end else begin
          count_next = count - 8'd1;
        end
      end
      STOP: begin
        stop = 1'b1;
        if (count == 8'd1) begin
          next_state = DONE;
          count_next = 8'd1;
        end else begin
          count_next = count - 8'd1;
        end
      end
      DONE: begin
        done       = winner_q ? 2'b10 : 2'b01;
        next_state = IDLE;
        count_next = 8'd0;
      end
      default: begin
        next_state = IDLE;
        count_next = 8'd0;
      end
    endcase
  end

  // State register plus grant-time latching of the winner's command; the
  // pointer moves to the requester that did not just win.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 8'd0;
      pointer  <= 1'b0;
      winner_q <= 1'b0;
      gnt      <= 2'b00;
      rw       <= 1'b0;
      addr     <= 7'd0;
      w_data   <= 8'd0;
    end else begin
      state <= next_state;
      count <= count_next;
      gnt   <= 2'b00;
      if (grant_now) begin
        gnt      <= winner ? 2'b10 : 2'b01;
        winner_q <= winner;
        pointer  <= ~winner;
        rw       <= winner ? rw1 : rw0;
        addr     <= winner ? addr1 : addr0;
        w_data   <= winner ? wdata1 : wdata0;
      end
    end
  end

endmodule
